// File: rtl/stream_demux_pkg.sv
// Shared constants and helpers for the stream demultiplexer.
// Supplies the default widths and the saturating counter increment.
package stream_demux_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int NUM_CH_DEF = 8;
    localparam int CNT_W_DEF  = 8;

    // Increment that sticks at the all-ones value of a w-bit counter (w < 64).
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int w);
        logic [63:0] max_val;
        max_val = (64'd1 << w) - 64'd1;
        return (value >= max_val) ? max_val : value + 64'd1;
    endfunction

endpackage

// File: rtl/stream_demux_if.sv
// Producer-side and consumer-side handshake bundle of the stream demultiplexer.
// master = bench/system side, slave = demux side.
interface stream_demux_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 8,
    parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        in_data;
    logic [SEL_W-1:0]         in_sel;
    logic [NUM_CH-1:0]        out_valid;
    logic [NUM_CH-1:0]        out_ready;
    logic [NUM_CH*DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/stream_demux_slot.sv
// One-entry holding register for a single demux output channel.
// A push in the same cycle as a pop reloads the slot without a bubble.
module demux_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic              full,
    output logic [DATA_W-1:0] data
);
    logic              full_reg;
    logic [DATA_W-1:0] data_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_reg <= 1'b0;
            data_reg <= '0;
        end else if (push) begin
            full_reg <= 1'b1;
            data_reg <= wdata;
        end else if (pop) begin
            // Data is left in place; it is don't-care while the slot is empty.
            full_reg <= 1'b0;
        end
    end

    assign full = full_reg;
    assign data = data_reg;
endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-NUM_CH stream demultiplexer with per-channel holding slots
// and a saturating counter of beats addressed to non-existent channels.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    stream_demux_if.slave    bus,
    output logic [CNT_W-1:0] drop_cnt
);
    logic [NUM_CH-1:0]        sel_onehot;
    logic [NUM_CH-1:0]        slot_free;
    logic [NUM_CH-1:0]        push_vec;
    logic [NUM_CH-1:0]        pop_vec;
    logic [NUM_CH-1:0]        full_vec;
    logic [NUM_CH*DATA_W-1:0] data_vec;
    logic                     in_range;
    logic                     ready;
    logic                     accept;
    logic [CNT_W-1:0]         drop_cnt_reg;

    // One-hot decode; indices >= NUM_CH decode to all zeros, which marks them out of range.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_decode
            assign sel_onehot[gi] = (bus.in_sel == SEL_W'(gi));
        end
    endgenerate

    assign in_range  = |sel_onehot;
    assign slot_free = ~full_vec | bus.out_ready;
    // Only the addressed channel's state feeds in_ready; other channels never stall the input.
    assign ready     = in_range ? |(sel_onehot & slot_free) : 1'b1;
    assign accept    = bus.in_valid && ready;
    assign push_vec  = accept ? sel_onehot : '0;
    assign pop_vec   = full_vec & bus.out_ready;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
            demux_slot #(.DATA_W(DATA_W)) u_slot (
                .clk   (clk),
                .rst_n (rst_n),
                .push  (push_vec[gi]),
                .pop   (pop_vec[gi]),
                .wdata (bus.in_data),
                .full  (full_vec[gi]),
                .data  (data_vec[gi*DATA_W +: DATA_W])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt_reg <= '0;
        end else if (accept && !in_range) begin
            drop_cnt_reg <= CNT_W'(sat_inc(64'(drop_cnt_reg), CNT_W));
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = full_vec;
    assign bus.out_data  = data_vec;
    assign drop_cnt      = drop_cnt_reg;
endmodule
